// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, fixed-latency unified memory
// between the fetch stage (IF) and the memory stage (DM). One access is in
// flight at a time; read data is steered back to the stage that issued it,
// with byte-lane handling for sb/lbu. DM normally wins a conflict. After
// STARVE_LIMIT consecutive DM grants that leave IF waiting, IF wins the next one.
// Optional: define ARB_PERF_CNT_EN to add the perf_* wait/conflict counters.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic                  dm_byte,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic                  dm_gnt,
    output logic                  dm_rvalid,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]           perf_if_wait,
    output logic [31:0]           perf_dm_wait,
    output logic [31:0]           perf_conflict,
`endif
    output logic                  stall_f,
    output logic                  stall_m
);

    typedef enum logic {IDLE, WAIT} state_e;

    // The WAIT counter runs from MEM_LATENCY-2 down to 0.
    localparam int CNT_W = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'((MEM_LATENCY > 2) ? MEM_LATENCY - 2 : 0);
    localparam int SC_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic [SC_W-1:0]       starve_cnt_q, starve_cnt_d;
    logic                  owner_dm_q, owner_dm_d;
    logic                  byte_q, byte_d;
    logic [1:0]            off_q, off_d;
    logic                  if_rvalid_q, if_rvalid_d;
    logic                  dm_rvalid_q, dm_rvalid_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, dm_rdata_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;

    logic                  can_grant;
    logic                  done;
    logic                  done_dm;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [7:0]            lane;
    logic [DATA_WIDTH-1:0] load_data;

    // Arbitration: grant only in IDLE and out of reset; DM first unless IF is starved.
    always_comb begin
        can_grant = rst_n && (state_q == IDLE);
        if_gnt    = can_grant && if_req && (!dm_req || (starve_cnt_q == STARVE_MAX));
        dm_gnt    = can_grant && dm_req && !if_gnt;
    end

    // Memory strobes come straight from the winner; address/wdata hold when idle.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        win_addr  = dm_gnt ? dm_addr : if_addr;
        mem_en    = if_gnt | dm_gnt;
        mem_we    = dm_gnt & dm_we;
        mem_be    = 4'b0000;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        if (mem_en) begin
            mem_addr = win_addr & ~ADDR_WIDTH'(3);
            mem_be   = (dm_gnt && dm_byte) ? (4'b0001 << dm_addr[1:0]) : 4'b1111;
        end
        if (dm_gnt) begin
            mem_wdata = dm_byte ? {4{dm_wdata[7:0]}} : dm_wdata;
        end
    end

    // Access sequencing: latch owner/lane at grant, count out the latency, pulse rvalid.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        owner_dm_d = owner_dm_q;
        byte_d     = byte_q;
        off_d      = off_q;
        done       = 1'b0;
        done_dm    = owner_dm_q;
        if (mem_en) begin
            owner_dm_d = dm_gnt;
            byte_d     = dm_gnt & dm_byte;
            off_d      = dm_addr[1:0];
        end
        if (MEM_LATENCY == 1) begin
            // Single-cycle memory: completion is the cycle after grant, no WAIT state.
            done    = mem_en;
            done_dm = dm_gnt;
        end else if (state_q == IDLE) begin
            if (mem_en) begin
                state_d    = WAIT;
                wait_cnt_d = WAIT_INIT;
            end
        end else begin
            if (wait_cnt_q == '0) begin
                state_d = IDLE;
                done    = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q - 1'b1;
            end
        end
        if_rvalid_d = done & ~done_dm;
        dm_rvalid_d = done & done_dm;
    end

    // Starvation counter: counts DM wins over a waiting IF, saturating at the limit.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (if_gnt || !if_req) begin
            starve_cnt_d = '0;
        end else if (dm_gnt && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // Return path: lbu picks and zero-extends one lane; the non-owner keeps its last data.
    always_comb begin
        lane      = mem_rdata[{off_q, 3'b000} +: 8];
        load_data = byte_q ? {{(DATA_WIDTH-8){1'b0}}, lane} : mem_rdata;
        if_rdata  = if_rvalid_q ? load_data : if_rdata_q;
        dm_rdata  = dm_rvalid_q ? load_data : dm_rdata_q;
    end

    assign if_rvalid = if_rvalid_q;
    assign dm_rvalid = dm_rvalid_q;
    assign stall_f   = if_req & ~if_rvalid;
    assign stall_m   = dm_req & ~dm_rvalid;

    // State and datapath registers; async reset discards any outstanding access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            starve_cnt_q <= '0;
            owner_dm_q   <= 1'b0;
            byte_q       <= 1'b0;
            off_q        <= 2'b00;
            if_rvalid_q  <= 1'b0;
            dm_rvalid_q  <= 1'b0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            owner_dm_q   <= owner_dm_d;
            byte_q       <= byte_d;
            off_q        <= off_d;
            if_rvalid_q  <= if_rvalid_d;
            dm_rvalid_q  <= dm_rvalid_d;
            if_rdata_q   <= if_rdata;
            dm_rdata_q   <= dm_rdata;
            mem_addr_q   <= mem_addr;
            mem_wdata_q  <= mem_wdata;
        end
    end

`ifdef ARB_PERF_CNT_EN
    // Saturating performance counters for stall cycles and arbitration conflicts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_if_wait  <= '0;
            perf_dm_wait  <= '0;
            perf_conflict <= '0;
        end else begin
            if (stall_f && (perf_if_wait != '1)) begin
                perf_if_wait <= perf_if_wait + 1'b1;
            end
            if (stall_m && (perf_dm_wait != '1)) begin
                perf_dm_wait <= perf_dm_wait + 1'b1;
            end
            if ((state_q == IDLE) && if_req && dm_req && (perf_conflict != '1)) begin
                perf_conflict <= perf_conflict + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the pipeline's fetch stage (IF) and memory stage (DM).
- Issues one access at a time to a fixed-latency memory and returns read data to the owner.
- Drives per-stage stall signals to the hazard logic.
- Handles word and byte accesses (lw/sw, lbu/sb) with lane steering.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, data width (fixed 32-bit lanes).
- MEM_LATENCY, 2, cycles from issue to mem_rdata valid; legal values >= 1.
- STARVE_LIMIT, 4, consecutive DM grants with IF waiting before IF is forced.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request, held until if_rvalid.
- if_addr  in  ADDR_WIDTH  fetch byte address.
- if_gnt  out  1  fetch issued this cycle.
- if_rvalid  out  1  fetch data valid (1-cycle pulse).
- if_rdata  out  DATA_WIDTH  fetched word.
- dm_req  in  1  data request, held until dm_rvalid.
- dm_we  in  1  1 = store.
- dm_byte  in  1  1 = byte access (sb/lbu), 0 = word.
- dm_addr  in  ADDR_WIDTH  data byte address.
- dm_wdata  in  DATA_WIDTH  store data; byte uses [7:0].
- dm_gnt  out  1  data access issued this cycle.
- dm_rvalid  out  1  data access complete (1-cycle pulse); also pulses for stores.
- dm_rdata  out  DATA_WIDTH  load data; lbu zero-extended.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_WIDTH  word-aligned address; [1:0] = 0.
- mem_be  out  4  byte enables.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_rdata  in  DATA_WIDTH  read data, valid MEM_LATENCY cycles after mem_en.
- stall_f  out  1  = if_req & ~if_rvalid.
- stall_m  out  1  = dm_req & ~dm_rvalid.

Behaviour:
- FSM states:
  - IDLE (may grant).
  - WAIT (access outstanding; lasts MEM_LATENCY-1 cycles, counter-driven; skipped when MEM_LATENCY = 1).
- Grant cycle T:
  - Grant only in IDLE.
  - gnt and mem_en are combinational in T; mem_* are driven from the winner's inputs.
  - Owner, dm_byte and addr[1:0] are registered at T.
- Completion:
  - rvalid is a registered pulse to the owner in cycle T+MEM_LATENCY.
  - rdata is derived from mem_rdata in that cycle.
  - FSM is IDLE in that cycle, so a back-to-back grant is allowed.
  - Throughput: one access per MEM_LATENCY cycles.
- Priority:
  - DM wins when both request (older instruction first).
  - A saturating counter starve_cnt increments on each DM grant while if_req is high.
  - When starve_cnt == STARVE_LIMIT, the next simultaneous grant goes to IF.
  - starve_cnt clears on any IF grant or when if_req is low.
- Lane rules:
  - Word: mem_be = 4'b1111; mem_wdata = dm_wdata.
  - Byte: mem_be = 4'b0001 << addr[1:0]; mem_wdata = {4{dm_wdata[7:0]}}.
  - lbu: dm_rdata = {24'b0, selected lane}.
  - Word address bits [1:0] are ignored; no misalignment fault.
- Idle memory outputs: mem_en, mem_we, mem_be = 0; mem_addr and mem_wdata hold their last values.
- Request withdrawn before grant (pipeline flush): no access, no rvalid.
- Request withdrawn after grant: the access completes and rvalid still pulses; the requester ignores it.
- rvalid goes only to the owner; the non-owner's rdata holds its previous value.
- Reset (async, any time, including mid-access):
  - State IDLE, counters 0, all gnt/rvalid/mem_en/mem_we/mem_be = 0, rdata registers 0.
  - Outstanding access is discarded: no rvalid after reset release.
- stall_f/stall_m are combinational and are 0 in reset because the requests are expected low; their formula still holds.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined: adds outputs perf_if_wait, perf_dm_wait and perf_conflict (32-bit each, reset 0, saturating).
  - perf_if_wait / perf_dm_wait increment each cycle stall_f / stall_m is 1.
  - perf_conflict increments each IDLE cycle in which both requests are high.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single fetch, MEM_LATENCY=2: if_req at T, if_addr=0x100, mem_rdata=0xDEADBEEF at T+2 -> if_gnt@T, mem_addr=0x100, mem_be=4'hF, if_rvalid@T+2 with if_rdata=0xDEADBEEF, stall_f high T..T+1.
- Conflict: both requests at T -> dm_gnt@T, dm_rvalid@T+2, if_gnt@T+2, if_rvalid@T+4.
- Byte store/load: sb addr=0x203 wdata=0x5A -> mem_be=4'b1000, mem_wdata=0x5A5A5A5A; then lbu 0x203 with mem_rdata=0x7F000000 -> dm_rdata=0x0000007F.
- Starvation: dm_req and if_req held high, STARVE_LIMIT=4 -> four DM grants, fifth grant to IF, starve_cnt back to 0.
- Reset mid-access: rst_n low at T+1 after a grant at T -> all outputs 0 immediately, no rvalid after release, fresh if_req granted the first cycle after release.
- Flush: if_req high one cycle while DM owns the port, then dropped -> no if_gnt, no if_rvalid; with ARB_PERF_CNT_EN, perf_if_wait = 1 and perf_conflict = 0.
